// File: rtl/edge_avalon_sequencer.sv
// Avalon-MM CSR front-end that sequences the edge-detector core handshake:
// start pulse, pixel loading, input-received, result draining, output-sent.
module edge_avalon_sequencer #(
    parameter int NUM_PIX = 64,
    parameter int NUM_OUT = 36,
    parameter int PIX_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       avs_address_i,
    input  logic             avs_write_i,
    input  logic [31:0]      avs_writedata_i,
    input  logic             avs_read_i,
    output logic [31:0]      avs_readdata_o,
    output logic             avs_waitrequest_o,
    output logic             start_o,
    output logic [PIX_W-1:0] pix_data_o,
    output logic             pix_wr_o,
    output logic             input_received_o,
    input  logic             data_available_i,
    input  logic [PIX_W-1:0] out_pix_i,
    output logic             out_next_o,
    output logic             output_sent_o
);

    localparam int CNT_W = $clog2(NUM_PIX + 1);

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_PIX_IN  = 3'd2;
    localparam logic [2:0] ADDR_PIX_OUT = 3'd3;
    localparam logic [2:0] ADDR_IN_CNT  = 3'd4;
    localparam logic [2:0] ADDR_OUT_CNT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_ARM     = 3'd2,
        ST_LOAD    = 3'd3,
        ST_PROCESS = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  in_cnt_r;
    logic [CNT_W-1:0]  out_cnt_r;
    logic              done_r;
    logic              err_r;
    logic              start_r;
    logic              in_rx_r;
    logic              out_sent_r;

    logic              start_req_s;
    logic              clr_req_s;
    logic              pix_in_wr_s;
    logic              pix_out_rd_s;
    logic              pix_accept_s;
    logic              pop_accept_s;
    logic              in_last_s;
    logic              out_last_s;
    logic              err_set_s;
    logic [31:0]       rdata_s;
    logic              unused_s;

    assign start_req_s  = avs_write_i && (avs_address_i == ADDR_CTRL) && avs_writedata_i[0];
    assign clr_req_s    = avs_write_i && (avs_address_i == ADDR_CTRL) && avs_writedata_i[1];
    assign pix_in_wr_s  = avs_write_i && (avs_address_i == ADDR_PIX_IN);
    assign pix_out_rd_s = avs_read_i && (avs_address_i == ADDR_PIX_OUT);
    assign pix_accept_s = pix_in_wr_s && (state_r == ST_LOAD);
    assign pop_accept_s = pix_out_rd_s && (state_r == ST_DRAIN);
    assign in_last_s    = pix_accept_s && (in_cnt_r == CNT_W'(NUM_PIX - 1));
    assign out_last_s   = pop_accept_s && (out_cnt_r == CNT_W'(NUM_OUT - 1));
    assign err_set_s    = (pix_in_wr_s && (state_r != ST_LOAD))
                        || (pix_out_rd_s && (state_r != ST_DRAIN))
                        || (start_req_s && (state_r != ST_IDLE));
    assign unused_s     = ^avs_writedata_i[31:PIX_W];

    // Next-state decode of the frame sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_req_s) state_next_s = ST_START;
                else             state_next_s = ST_IDLE;
            end
            ST_START: state_next_s = ST_ARM;
            ST_ARM:   state_next_s = ST_LOAD;
            ST_LOAD: begin
                if (in_last_s) state_next_s = ST_PROCESS;
                else           state_next_s = ST_LOAD;
            end
            ST_PROCESS: begin
                if (data_available_i) state_next_s = ST_DRAIN;
                else                  state_next_s = ST_PROCESS;
            end
            ST_DRAIN: begin
                if (out_last_s) state_next_s = ST_IDLE;
                else            state_next_s = ST_DRAIN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, counters, sticky flags and registered handshake pulses
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            in_cnt_r   <= {CNT_W{1'b0}};
            out_cnt_r  <= {CNT_W{1'b0}};
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            start_r    <= 1'b0;
            in_rx_r    <= 1'b0;
            out_sent_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            start_r    <= (state_next_s == ST_START);
            in_rx_r    <= in_last_s;
            out_sent_r <= out_last_s;
            if ((state_r == ST_IDLE) && start_req_s) begin
                in_cnt_r  <= {CNT_W{1'b0}};
                out_cnt_r <= {CNT_W{1'b0}};
                done_r    <= 1'b0;
            end else begin
                if (pix_accept_s) in_cnt_r <= in_cnt_r + CNT_W'(1);
                if (pop_accept_s) out_cnt_r <= out_cnt_r + CNT_W'(1);
                if (out_last_s)   done_r <= 1'b1;
            end
            // A fresh error wins over a clear arriving in the same cycle
            if (err_set_s)      err_r <= 1'b1;
            else if (clr_req_s) err_r <= 1'b0;
        end
    end

    // Zero-latency read mux; only PIX_OUT in DRAIN returns core data
    always_comb begin
        rdata_s = 32'd0;
        if (avs_read_i) begin
            case (avs_address_i)
                ADDR_STATUS: rdata_s = {27'd0, err_r, (state_r == ST_DRAIN),
                                        (state_r == ST_LOAD), done_r,
                                        (state_r != ST_IDLE)};
                ADDR_PIX_OUT: begin
                    if (state_r == ST_DRAIN) rdata_s = 32'(out_pix_i);
                    else                     rdata_s = 32'd0;
                end
                ADDR_IN_CNT:  rdata_s = 32'(in_cnt_r);
                ADDR_OUT_CNT: rdata_s = 32'(out_cnt_r);
                default:      rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign avs_readdata_o    = rdata_s;
    assign avs_waitrequest_o = 1'b0;
    assign start_o           = start_r;
    assign pix_wr_o          = pix_accept_s;
    assign pix_data_o        = pix_accept_s ? avs_writedata_i[PIX_W-1:0] : {PIX_W{1'b0}};
    assign input_received_o  = in_rx_r;
    assign out_next_o        = pop_accept_s;
    assign output_sent_o     = out_sent_r;

endmodule
